// File: rtl/regfile.sv
// -----------------------------------------------------------------------------
// regfile
//   32 x 32-bit RISC-V integer register file for the multi-cycle CPU.
//   Two combinational read ports feed the A/writedata latch stage. One
//   synchronous write port is driven from the writeback result. A third
//   combinational read port is provided for debug.
//   x0 is hardwired to zero and is never stored.
//
// Configuration macro:
//   REGFILE_BYPASS_EN  When defined, a write in the current cycle is
//                      forwarded to any read port whose address matches
//                      A3. Forwarding is suppressed while rst_n is low.
//                      When undefined, reads always return stored contents.
//
// Parameters:
//   XLEN   data width of each register
//   NREGS  number of architectural registers (address width = $clog2(NREGS))
//
// Ports:
//   clk       in   system clock; writes occur on the rising edge
//   rst_n     in   asynchronous active-low reset; clears every register
//   A1        in   read port 1 address (rs1)
//   A2        in   read port 2 address (rs2)
//   A3        in   write address (rd)
//   WD3       in   write data
//   WE3       in   write enable, sampled at posedge clk
//   RD1       out  read data 1 (combinational)
//   RD2       out  read data 2 (combinational)
//   dbg_addr  in   debug read address
//   dbg_data  out  debug read data (combinational, same rules as RD1)
// -----------------------------------------------------------------------------
module regfile #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32,
  localparam int unsigned AW   = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   A1,
  input  logic [AW-1:0]   A2,
  input  logic [AW-1:0]   A3,
  input  logic [XLEN-1:0] WD3,
  input  logic            WE3,
  output logic [XLEN-1:0] RD1,
  output logic [XLEN-1:0] RD2,
  input  logic [AW-1:0]   dbg_addr,
  output logic [XLEN-1:0] dbg_data
);

  logic [XLEN-1:0] regs [NREGS];
  logic            wr_en;

  // A write to x0 is discarded here so x0 never holds anything but reset zero.
  assign wr_en = WE3 && (A3 != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[A3] <= WD3;
    end
  end

`ifdef REGFILE_BYPASS_EN
  // Forwarding: a matching in-flight write overrides the stored value. The
  // rst_n gate keeps reads at zero while reset holds, even if WE3 is high.
  always_comb begin
    RD1 = (A1 == '0) ? '0 : regs[A1];
    if (wr_en && (A3 == A1)) RD1 = WD3;
    if (!rst_n) RD1 = '0;
  end

  always_comb begin
    RD2 = (A2 == '0) ? '0 : regs[A2];
    if (wr_en && (A3 == A2)) RD2 = WD3;
    if (!rst_n) RD2 = '0;
  end

  always_comb begin
    dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];
    if (wr_en && (A3 == dbg_addr)) dbg_data = WD3;
    if (!rst_n) dbg_data = '0;
  end
`else
  // Stored contents only; reset already clears the array asynchronously.
  always_comb begin
    RD1 = (A1 == '0) ? '0 : regs[A1];
  end

  always_comb begin
    RD2 = (A2 == '0) ? '0 : regs[A2];
  end

  always_comb begin
    dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];
  end
`endif

endmodule
